// File: rtl/room_navigator.sv
// room_navigator: per-frame player controller for a tiled room map.
//
// Each frame the visible raster is scanned for wall pixels (nonzero mapData) that fall
// inside the player box. At the VBlank rising edge the frame verdict is evaluated: a hit
// restores the last collision-free position, otherwise the current position becomes the
// new safe one. One cycle later the buttons are sampled once and the player moves,
// crossing into a neighbouring room at a screen edge (clamped at the map border).
//
// Ports
//   clk_vga            pixel clock
//   reset              synchronous active-low reset
//   CurrentX/CurrentY  raster position
//   HBlank/VBlank      blanking flags
//   mapData            room pixel colour, one cycle behind CurrentX/CurrentY
//   btn                {up, down, left, right}, active-high levels
//   mapX/mapY          current room coordinates
//   playerX/playerY    top-left corner of the player box
//   collision          wall hit detected in the last evaluated frame
//   frame_tick         one-cycle pulse marking the movement update

module room_navigator #(
    parameter int unsigned PSIZE    = 8,
    parameter int unsigned STEP     = 2,
    parameter int unsigned SCR_W    = 640,
    parameter int unsigned SCR_H    = 480,
    parameter int unsigned START_MX = 3,
    parameter int unsigned START_MY = 5,
    parameter int unsigned START_X  = 316,
    parameter int unsigned START_Y  = 400
) (
    input  logic       clk_vga,
    input  logic       reset,
    input  logic [9:0] CurrentX,
    input  logic [8:0] CurrentY,
    input  logic       HBlank,
    input  logic       VBlank,
    input  logic [7:0] mapData,
    input  logic [3:0] btn,
    output logic [3:0] mapX,
    output logic [3:0] mapY,
    output logic [9:0] playerX,
    output logic [8:0] playerY,
    output logic       collision,
    output logic       frame_tick
);

    // One bit wider than the position registers so no sum or difference can wrap.
    localparam logic [10:0] XStep  = 11'(STEP);
    localparam logic [10:0] XMax   = 11'(SCR_W - PSIZE);
    localparam logic [10:0] XSpan  = 11'(PSIZE - 1);
    localparam logic [9:0]  YStep  = 10'(STEP);
    localparam logic [9:0]  YMax   = 10'(SCR_H - PSIZE);
    localparam logic [9:0]  YSpan  = 10'(PSIZE - 1);
    localparam logic [9:0]  StartX = 10'(START_X);
    localparam logic [8:0]  StartY = 9'(START_Y);
    localparam logic [3:0]  StartMx = 4'(START_MX);
    localparam logic [3:0]  StartMy = 4'(START_MY);

    typedef enum logic [1:0] {
        StHold,
        StScan,
        StEval,
        StApply
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] cx_q;
    logic [8:0] cy_q;
    logic       act_q;
    logic       vblank_q;
    logic       sync_q;
    logic       hit_q, hit_d;
    logic [9:0] px_q, px_d, safe_x_q, safe_x_d;
    logic [8:0] py_q, py_d, safe_y_q, safe_y_d;
    logic [3:0] mx_q, mx_d, my_q, my_d;
    logic       coll_q, coll_d;
    logic       tick_q, tick_d;

    logic [10:0] px_w, px_plus, px_minus, box_x_hi, cx_w;
    logic [9:0]  py_w, py_plus, py_minus, box_y_hi, cy_w;
    logic [4:0]  mx_inc, mx_dec, my_inc, my_dec;
    logic        pix_hit;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic        x_room, y_room;

    assign px_w     = {1'b0, px_q};
    assign px_plus  = px_w + XStep;
    assign px_minus = px_w - XStep;
    assign box_x_hi = px_w + XSpan;
    assign cx_w     = {1'b0, cx_q};
    assign py_w     = {1'b0, py_q};
    assign py_plus  = py_w + YStep;
    assign py_minus = py_w - YStep;
    assign box_y_hi = py_w + YSpan;
    assign cy_w     = {1'b0, cy_q};
    assign mx_inc   = {1'b0, mx_q} + 5'd1;
    assign mx_dec   = {1'b0, mx_q} - 5'd1;
    assign my_inc   = {1'b0, my_q} + 5'd1;
    assign my_dec   = {1'b0, my_q} - 5'd1;

    assign {btn_up, btn_down, btn_left, btn_right} = btn;

    // The delayed raster position lines up with the mapData that belongs to it.
    assign pix_hit = act_q && (mapData != 8'd0) &&
                     (cx_w >= px_w) && (cx_w <= box_x_hi) &&
                     (cy_w >= py_w) && (cy_w <= box_y_hi);

    always_comb begin
        state_d  = state_q;
        hit_d    = hit_q;
        px_d     = px_q;
        py_d     = py_q;
        mx_d     = mx_q;
        my_d     = my_q;
        safe_x_d = safe_x_q;
        safe_y_d = safe_y_q;
        coll_d   = coll_q;
        tick_d   = 1'b0;
        x_room   = 1'b0;
        y_room   = 1'b0;

        unique case (state_q)
            StHold: begin
                hit_d = 1'b0;
                // sync_q keeps a frame that was already running at reset release out.
                if (sync_q && !VBlank) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                hit_d = hit_q | pix_hit;
                if (!vblank_q && VBlank) begin
                    state_d = StEval;
                end
            end
            StEval: begin
                coll_d = hit_q;
                if (hit_q) begin
                    px_d = safe_x_q;
                    py_d = safe_y_q;
                end else begin
                    safe_x_d = px_q;
                    safe_y_d = py_q;
                end
                // Registered, so the pulse is visible during the APPLY cycle.
                tick_d  = 1'b1;
                state_d = StApply;
            end
            StApply: begin
                state_d = StHold;
                if (!coll_q) begin
                    if (btn_right && !btn_left) begin
                        if (px_plus <= XMax) begin
                            px_d = px_plus[9:0];
                        end else if (mx_q != 4'hF) begin
                            px_d   = '0;
                            mx_d   = mx_inc[3:0];
                            x_room = 1'b1;
                        end else begin
                            px_d = XMax[9:0];
                        end
                    end else if (btn_left && !btn_right) begin
                        if (px_w >= XStep) begin
                            px_d = px_minus[9:0];
                        end else if (mx_q != 4'h0) begin
                            px_d   = XMax[9:0];
                            mx_d   = mx_dec[3:0];
                            x_room = 1'b1;
                        end else begin
                            px_d = '0;
                        end
                    end

                    if (btn_up && !btn_down) begin
                        if (py_w >= YStep) begin
                            py_d = py_minus[8:0];
                        end else if (my_q != 4'hF) begin
                            py_d   = YMax[8:0];
                            my_d   = my_inc[3:0];
                            y_room = 1'b1;
                        end else begin
                            py_d = '0;
                        end
                    end else if (btn_down && !btn_up) begin
                        if (py_plus <= YMax) begin
                            py_d = py_plus[8:0];
                        end else if (my_q != 4'h0) begin
                            py_d   = '0;
                            my_d   = my_dec[3:0];
                            y_room = 1'b1;
                        end else begin
                            py_d = YMax[8:0];
                        end
                    end

                    if (x_room || y_room) begin
                        safe_x_d = px_d;
                        safe_y_d = py_d;
                        coll_d   = 1'b0;
                    end
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_ff @(posedge clk_vga) begin
        if (!reset) begin
            state_q  <= StHold;
            cx_q     <= '0;
            cy_q     <= '0;
            act_q    <= 1'b0;
            vblank_q <= 1'b0;
            sync_q   <= 1'b0;
            hit_q    <= 1'b0;
            px_q     <= StartX;
            py_q     <= StartY;
            mx_q     <= StartMx;
            my_q     <= StartMy;
            safe_x_q <= StartX;
            safe_y_q <= StartY;
            coll_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= CurrentX;
            cy_q     <= CurrentY;
            act_q    <= !HBlank && !VBlank;
            vblank_q <= VBlank;
            sync_q   <= sync_q | VBlank;
            hit_q    <= hit_d;
            px_q     <= px_d;
            py_q     <= py_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            safe_x_q <= safe_x_d;
            safe_y_q <= safe_y_d;
            coll_q   <= coll_d;
            tick_q   <= tick_d;
        end
    end

    assign mapX       = mx_q;
    assign mapY       = my_q;
    assign playerX    = px_q;
    assign playerY    = py_q;
    assign collision  = coll_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_room_navigator.sv
// Directed bench for room_navigator. A compact raster driver scans only a window around
// the player (or nothing at all for movement-only frames); the map model returns wall
// pixels one clock after the coordinates, like the real map generator.

module tb_room_navigator;

    logic       clk_vga = 1'b0;
    logic       reset;
    logic [9:0] CurrentX;
    logic [8:0] CurrentY;
    logic       HBlank;
    logic       VBlank;
    logic [7:0] mapData;
    logic [3:0] btn;
    logic [3:0] mapX;
    logic [3:0] mapY;
    logic [9:0] playerX;
    logic [8:0] playerY;
    logic       collision;
    logic       frame_tick;

    int n_checks = 0;
    int n_errors = 0;
    int tick_cnt = 0;
    int t0;

    int wall_en = 0;
    int wx0 = 0, wx1 = 0, wy0 = 0, wy1 = 0;

    always #5 clk_vga = ~clk_vga;

    room_navigator dut (
        .clk_vga    (clk_vga),
        .reset      (reset),
        .CurrentX   (CurrentX),
        .CurrentY   (CurrentY),
        .HBlank     (HBlank),
        .VBlank     (VBlank),
        .mapData    (mapData),
        .btn        (btn),
        .mapX       (mapX),
        .mapY       (mapY),
        .playerX    (playerX),
        .playerY    (playerY),
        .collision  (collision),
        .frame_tick (frame_tick)
    );

    // Map generator model: one clock of latency from coordinates to colour.
    always @(posedge clk_vga) begin
        if (wall_en != 0 && int'(CurrentX) >= wx0 && int'(CurrentX) <= wx1 &&
            int'(CurrentY) >= wy0 && int'(CurrentY) <= wy1) begin
            mapData <= 8'hFF;
        end else begin
            mapData <= 8'h00;
        end
    end

    always @(negedge clk_vga) begin
        if (frame_tick) tick_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_walls(input int en, input int x0, input int x1, input int y0,
                             input int y1);
        wall_en = en;
        wx0 = x0;
        wx1 = x1;
        wy0 = y0;
        wy1 = y1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        VBlank   = 1'b1;
        HBlank   = 1'b1;
        btn      = 4'b0000;
        CurrentX = '0;
        CurrentY = '0;
        repeat (3) @(negedge clk_vga);
        reset = 1'b1;
        @(negedge clk_vga);
    endtask

    task automatic drive_pixel(input int x, input int y);
        HBlank   = 1'b0;
        CurrentX = 10'(x);
        CurrentY = 9'(y);
        @(negedge clk_vga);
    endtask

    // Active window x0..x1 by y0..y1 (empty when y1 < y0), then a short VBlank.
    task automatic run_frame(input int x0, input int x1, input int y0, input int y1);
        VBlank = 1'b0;
        HBlank = 1'b1;
        @(negedge clk_vga);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) drive_pixel(x, y);
            HBlank = 1'b1;
            @(negedge clk_vga);
        end
        VBlank = 1'b1;
        HBlank = 1'b1;
        repeat (5) @(negedge clk_vga);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame(0, -1, 0, -1);
    endtask

    initial begin
        reset    = 1'b0;
        VBlank   = 1'b1;
        HBlank   = 1'b1;
        btn      = 4'b0000;
        CurrentX = '0;
        CurrentY = '0;
        @(negedge clk_vga);
        do_reset();

        check_eq("rst_mapX", mapX, 3);
        check_eq("rst_mapY", mapY, 5);
        check_eq("rst_playerX", playerX, 316);
        check_eq("rst_playerY", playerY, 400);
        check_eq("rst_collision", collision, 0);
        check_eq("rst_frame_tick", frame_tick, 0);

        // Empty room, right held for 10 frames.
        set_walls(0, 0, 0, 0, 0);
        btn = 4'b0001;
        t0 = tick_cnt;
        for (int i = 0; i < 10; i++) run_frame(314, 326, 399, 401);
        check_eq("right10_playerX", playerX, 336);
        check_eq("right10_mapX", mapX, 3);
        check_eq("right10_collision", collision, 0);
        check_eq("right10_ticks", tick_cnt - t0, 10);

        // Walk to the right edge and cross into the next room, then back.
        run_frames(148);
        check_eq("edge_playerX", playerX, 632);
        run_frames(1);
        check_eq("exitR_playerX", playerX, 0);
        check_eq("exitR_mapX", mapX, 4);
        check_eq("exitR_mapY", mapY, 5);
        btn = 4'b0010;
        run_frames(1);
        check_eq("exitL_playerX", playerX, 632);
        check_eq("exitL_mapX", mapX, 3);

        // Collision: move once, then hit a wall segment and get pushed back.
        do_reset();
        btn = 4'b0001;
        run_frames(1);
        check_eq("pre_wall_playerX", playerX, 318);
        set_walls(1, 320, 327, 400, 400);
        run_frame(310, 330, 398, 409);
        check_eq("wall_collision", collision, 1);
        check_eq("wall_restore_playerX", playerX, 316);
        check_eq("wall_playerY", playerY, 400);
        set_walls(0, 0, 0, 0, 0);
        btn = 4'b0000;
        run_frame(310, 330, 398, 409);
        check_eq("clear_collision", collision, 0);

        // Alignment: wall just outside the box is ignored, just inside is seen.
        set_walls(1, 324, 324, 400, 400);
        run_frame(310, 330, 398, 409);
        check_eq("outside_collision", collision, 0);
        set_walls(1, 323, 323, 407, 407);
        run_frame(310, 330, 398, 409);
        check_eq("inside_collision", collision, 1);
        check_eq("inside_playerX", playerX, 316);
        set_walls(0, 0, 0, 0, 0);
        run_frames(1);
        check_eq("inside_clear", collision, 0);

        // Up through rooms to the top of the map, then clamp.
        btn = 4'b1000;
        run_frames(200);
        check_eq("top_playerY", playerY, 0);
        run_frames(1);
        check_eq("exitU_playerY", playerY, 472);
        check_eq("exitU_mapY", mapY, 6);
        run_frames(9 * 237 + 236);
        check_eq("map_top_playerY", playerY, 0);
        check_eq("map_top_mapY", mapY, 15);
        run_frames(1);
        check_eq("clamp_playerY", playerY, 0);
        check_eq("clamp_mapY", mapY, 15);
        btn = 4'b0100;
        run_frames(1);
        check_eq("down_playerY", playerY, 2);
        btn = 4'b1100;
        run_frames(1);
        check_eq("updown_playerY", playerY, 2);
        btn = 4'b1111;
        run_frames(1);
        check_eq("all_playerY", playerY, 2);
        check_eq("all_playerX", playerX, 316);

        // Reset in the middle of a scan that has already hit a wall.
        btn = 4'b0000;
        set_walls(1, 300, 340, 0, 20);
        t0 = tick_cnt;
        VBlank = 1'b0;
        HBlank = 1'b1;
        @(negedge clk_vga);
        for (int y = 0; y <= 5; y++) begin
            for (int x = 310; x <= 330; x++) drive_pixel(x, y);
        end
        reset = 1'b0;
        drive_pixel(331, 5);
        drive_pixel(332, 5);
        reset = 1'b1;
        drive_pixel(333, 5);
        check_eq("midrst_mapX", mapX, 3);
        check_eq("midrst_mapY", mapY, 5);
        check_eq("midrst_playerX", playerX, 316);
        check_eq("midrst_playerY", playerY, 400);
        check_eq("midrst_collision", collision, 0);
        check_eq("midrst_frame_tick", frame_tick, 0);
        for (int x = 334; x <= 340; x++) drive_pixel(x, 5);
        VBlank = 1'b1;
        HBlank = 1'b1;
        repeat (6) @(negedge clk_vga);
        check_eq("midrst_no_tick", tick_cnt - t0, 0);
        set_walls(0, 0, 0, 0, 0);
        run_frames(1);
        check_eq("midrst_first_tick", tick_cnt - t0, 1);
        check_eq("midrst_after_collision", collision, 0);
        check_eq("midrst_after_playerX", playerX, 316);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/room_navigator.md
ROOM_NAVIGATOR -- requirements
Module: room_navigator

Interface
REQ-001 SHALL have parameters: PSIZE 8, player box edge in pixels; STEP 2, pixels moved per frame; SCR_W 640; SCR_H 480; START_MX 3; START_MY 5; START_X 316; START_Y 400.
REQ-002 SHALL have ports: clk_vga in 1, pixel clock; reset in 1, synchronous active-low reset.
REQ-003 SHALL have ports: CurrentX in 10 and CurrentY in 9, raster position; HBlank in 1 and VBlank in 1, blanking flags.
REQ-004 SHALL have port: mapData in 8, room pixel colour, valid one clk_vga cycle after the CurrentX/CurrentY it corresponds to; nonzero means wall.
REQ-005 SHALL have port: btn in 4, {up,down,left,right}, level-sensitive, active-high.
REQ-006 SHALL have ports: mapX out 4 and mapY out 4, current room coordinates driven to the map generator.
REQ-007 SHALL have ports: playerX out 10 and playerY out 9, top-left corner of the player box.
REQ-008 SHALL have ports: collision out 1, wall hit in last frame; frame_tick out 1, one-cycle update pulse.

Function
REQ-009 SHALL implement FSM states HOLD, SCAN, EVAL and APPLY.
REQ-010 HOLD SHALL clear the hit accumulator and go to SCAN on the first cycle VBlank is low.
REQ-011 SCAN SHALL register CurrentX, CurrentY and active (=!HBlank && !VBlank) each cycle, delaying them one cycle to align with mapData.
REQ-012 SCAN SHALL set hit when, for the delayed position: active, mapData != 0, X within [playerX, playerX+PSIZE-1] and Y within [playerY, playerY+PSIZE-1].
REQ-013 SCAN SHALL go to EVAL on the VBlank rising edge (low previous cycle, high now).
REQ-014 EVAL SHALL copy hit to collision.
REQ-015 EVAL SHALL, when hit=1, restore the position from the last-safe registers; when hit=0, load last-safe from the current position; then go to APPLY.
REQ-016 APPLY SHALL pulse frame_tick for exactly this cycle.
REQ-017 APPLY SHALL apply no movement when collision=1; otherwise it SHALL sample btn once.
REQ-018 APPLY SHALL ignore an axis when both of its opposing buttons are set.
REQ-019 Right SHALL give X+STEP when X+STEP <= SCR_W-PSIZE; else X=0 and mapX+1.
REQ-020 Left SHALL give X-STEP when X >= STEP; else X=SCR_W-PSIZE and mapX-1.
REQ-021 Up SHALL give Y-STEP when Y >= STEP; else Y=SCR_H-PSIZE and mapY+1.
REQ-022 Down SHALL give Y+STEP when Y+STEP <= SCR_H-PSIZE; else Y=0 and mapY-1.
REQ-023 When mapX or mapY is at 15 (increment) or 0 (decrement), the position SHALL clamp to the edge and the room SHALL NOT change; no 4-bit wrap.
REQ-024 Both axes SHALL be evaluated independently in the same APPLY; a diagonal corner exit changes mapX and mapY together.
REQ-025 On any room change, last-safe SHALL load the new position and collision SHALL clear.
REQ-026 APPLY SHALL go to HOLD.
REQ-027 All outputs SHALL be registered; updates SHALL occur only in EVAL or APPLY, and never during active video.
REQ-028 All arithmetic SHALL use widths one bit wider than the operand, with no unsigned underflow.

Reset
REQ-029 reset=0 at a clk_vga edge SHALL set mapX=START_MX, mapY=START_MY, playerX=START_X, playerY=START_Y, last-safe=start, collision=0, frame_tick=0, hit=0 and state HOLD.
REQ-030 Reset mid-frame SHALL discard the partial frame; the next frame's SCAN SHALL start only after VBlank is low.

Verification
REQ-031 Scenario: reset, then empty room (mapData=0), btn=right held 10 frames -> playerX 316->336, mapX=3, collision=0, 10 frame_tick pulses.
REQ-032 Scenario: playerX=632, btn=right -> next APPLY gives playerX=0, mapX=4, mapY unchanged.
REQ-033 Scenario: wall pixels (mapData=8'hFF) only at (320..327, 400) with the player at 316,400 -> collision=1 after EVAL; position restored to last safe; no move that frame.
REQ-034 Scenario: mapData nonzero only at the delayed pixel just outside the box (x=324 with playerX=316) -> collision stays 0, proving 1-cycle alignment.
REQ-035 Scenario: playerY=0, mapY=15, btn=up -> playerY=0, mapY=15; then btn=up+down -> no Y motion.
REQ-036 Scenario: reset asserted during SCAN with hit set -> outputs at reset values; first frame_tick only after a full VBlank-low/VBlank-high cycle.
